mdc_multi_stream_ctrl_fsm: RTL
==============================

// Module: mdc_multi_stream_ctrl_fsm
// PURPOSE
// - Job-sequencing FSM for MDC-generated HWPEs with N_IN source and N_OUT sink streams.
// - Sits between hwpe_ctrl_slave (trigger/done) and the streamers/engine.
// - Starts all streams together and counts output handshakes per sink against programmable limits.
// - Closes the job once every sink has hit its limit and every source has reported done.
// PARAMETERS
// - N_IN   2   number of source (memory->engine) streams, >=1
// - N_OUT  2   number of sink (engine->memory) streams, >=1
// - CNT_W  32  width of per-sink transfer counters and limits
// - WDOG_W 16  watchdog counter width; used only with MDC_CTRL_WATCHDOG_EN
// PORTS
// - clk_i         in   1            clock
// - rst_ni        in   1            async reset, active low
// - clear_i       in   1            sync soft clear from slave
// - start_i       in   1            job trigger pulse from slave
// - cnt_limit_i   in   N_OUT*CNT_W  per-sink transfer count minus one; stable while busy_o
// - in_ready_i    in   N_IN         source streamer idle/ready to start
// - out_ready_i   in   N_OUT        sink streamer idle/ready to start
// - in_done_i     in   N_IN         source streamer done pulse
// - out_valid_i   in   N_OUT        sink stream valid, engine side
// - out_hs_rdy_i  in   N_OUT        sink stream ready, engine side
// - in_start_o    out  N_IN         source start pulse
// - out_start_o   out  N_OUT        sink start pulse
// - engine_en_o   out  1            engine enable, high during COMPUTE/DRAIN
// - busy_o        out  1            job in progress, high in every state except IDLE
// - done_o        out  1            one-cycle job-complete pulse to slave
// - ovf_o         out  1            sticky: handshake seen on an already-complete sink
// - timeout_o     out  1            sticky watchdog flag
// BEHAVIOUR
// - Reset/clear: state=IDLE; counters, sticky done/complete flags, ovf_o and timeout_o = 0; all outputs 0.
// - clear_i has priority over every other event; a mid-job clear emits no done_o.
// - IDLE: start_i=1 -> WAIT_RDY. start_i in any other state is ignored.
// - WAIT_RDY: &in_ready_i && &out_ready_i -> START. Otherwise hold; no timeout in this state.
// - START: in_start_o='1, out_start_o='1 for exactly this one cycle -> COMPUTE.
//   - start_i->start pulse latency: 2 cycles min.
// - COMPUTE, per sink k:
//   - A handshake is out_valid_i[k]&&out_hs_rdy_i[k].
//   - On a handshake with cnt[k]==cnt_limit_i[k]: set cmp[k], freeze cnt[k].
//   - On a handshake otherwise: cnt[k]++.
//   - A limit of all-ones gives 2^CNT_W transfers with no counter wrap.
// - COMPUTE/DRAIN:
//   - in_done_i[j] sets sticky idn[j]; done pulses are captured even before sinks finish.
//   - A handshake on a sink with cmp[k] already set sets ovf_o and is not counted.
// - COMPUTE: &cmp -> DRAIN. If &idn also holds in that cycle -> FINISHED directly.
// - DRAIN: engine_en_o stays 1; &idn -> FINISHED.
// - FINISHED:
//   - done_o=1 for one cycle; cnt, cmp and idn cleared -> IDLE.
//   - ovf_o and timeout_o persist until the next start_i accepted in IDLE, or clear_i.
// - Simultaneous events:
//   - Last handshake and in_done in the same cycle are both captured.
//   - Multiple sinks completing in the same cycle are all captured.
// - Outputs are registered except in_start_o, out_start_o and done_o, which decode the current state.
// CONFIGURATION
// - MDC_CTRL_WATCHDOG_EN defined:
//   - A WDOG_W-bit counter runs in COMPUTE/DRAIN.
//   - It resets on any sink handshake or in_done_i bit.
//   - At all-ones it sets timeout_o and moves to FINISHED; done_o still pulses.
// - MDC_CTRL_WATCHDOG_EN undefined: no watchdog logic; timeout_o tied 0; WDOG_W unused.
// TESTING
// - N_OUT=2, limits {3,7}, ready high:
//   - sink0 gets 4 handshakes and sink1 gets 8, then in_done='1.
//   - Expect done_o one cycle after DRAIN exit, busy_o low next cycle, ovf_o=0.
// - in_ready_i=2'b01 for 5 cycles after start_i:
//   - No start pulses during that time; in_start_o/out_start_o pulse 1 cycle after readiness.
// - in_done_i pulsed before sinks finish, then limits reached:
//   - Direct COMPUTE->FINISHED with no DRAIN wait; done_o=1.
// - Limit 0 on sink0, 2 handshakes on sink0 -> ovf_o=1 after the 2nd, cnt unchanged.
//   - Next start_i clears ovf_o.
// - clear_i in COMPUTE after 3 handshakes:
//   - Next cycle IDLE, busy_o=0, no done_o.
//   - A new job with limit 3 needs 4 fresh handshakes.
// - MDC_CTRL_WATCHDOG_EN, WDOG_W=4, stall sinks in COMPUTE:
//   - timeout_o=1 after 15 idle cycles, then done_o pulse.

Source files
------------

// File: rtl/mdc_multi_stream_ctrl_fsm_if.sv
// Handshake bundle between the MDC job-sequencing FSM and its surroundings
// (control slave, source/sink streamers, engine). The FSM uses the master modport.
interface mdc_multi_stream_ctrl_fsm_if #(
    parameter int unsigned N_IN  = 2,
    parameter int unsigned N_OUT = 2,
    parameter int unsigned CNT_W = 32
);
    logic                   clear_i;
    logic                   start_i;
    logic [N_OUT*CNT_W-1:0] cnt_limit_i;
    logic [N_IN-1:0]        in_ready_i;
    logic [N_OUT-1:0]       out_ready_i;
    logic [N_IN-1:0]        in_done_i;
    logic [N_OUT-1:0]       out_valid_i;
    logic [N_OUT-1:0]       out_hs_rdy_i;
    logic [N_IN-1:0]        in_start_o;
    logic [N_OUT-1:0]       out_start_o;
    logic                   engine_en_o;
    logic                   busy_o;
    logic                   done_o;
    logic                   ovf_o;
    logic                   timeout_o;

    modport master (
        input  clear_i, start_i, cnt_limit_i, in_ready_i, out_ready_i,
               in_done_i, out_valid_i, out_hs_rdy_i,
        output in_start_o, out_start_o, engine_en_o, busy_o, done_o,
               ovf_o, timeout_o
    );

    modport slave (
        output clear_i, start_i, cnt_limit_i, in_ready_i, out_ready_i,
               in_done_i, out_valid_i, out_hs_rdy_i,
        input  in_start_o, out_start_o, engine_en_o, busy_o, done_o,
               ovf_o, timeout_o
    );
endinterface

// File: rtl/mdc_multi_stream_ctrl_fsm.sv
// Job-sequencing FSM for MDC HWPEs: starts all streams, counts sink handshakes
// against per-sink limits, closes the job on all-sinks-complete and all-sources-done.
// Optional watchdog: define MDC_CTRL_WATCHDOG_EN.
module mdc_multi_stream_ctrl_fsm #(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned N_OUT  = 2,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned WDOG_W = 16
) (
    input logic                         clk_i,
    input logic                         rst_ni,
    mdc_multi_stream_ctrl_fsm_if.master ctrl
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RDY = 3'd1,
        START    = 3'd2,
        COMPUTE  = 3'd3,
        DRAIN    = 3'd4,
        FINISHED = 3'd5
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q [N_OUT];
    logic [N_OUT-1:0] cmp_q;
    logic [N_IN-1:0]  idn_q;
    logic             ovf_q;
    logic             busy_q;
    logic             engine_en_q;
    logic             timeout_q;

    logic [N_OUT-1:0] hs;
    logic             active;
    logic             all_ready;
    logic             start_acc;
    logic             wdog_fire;

    assign hs        = ctrl.out_valid_i & ctrl.out_hs_rdy_i;
    assign active    = (state_q == COMPUTE) || (state_q == DRAIN);
    assign all_ready = (&ctrl.in_ready_i) && (&ctrl.out_ready_i);
    assign start_acc = (state_q == IDLE) && ctrl.start_i && !ctrl.clear_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Completion is judged on the registered sticky flags, so the cycle that
    // sets the last flag is seen one cycle later.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ctrl.start_i) state_d = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (all_ready) state_d = START;
            end
            START: begin
                state_d = COMPUTE;
            end
            COMPUTE: begin
                if (wdog_fire) begin
                    state_d = FINISHED;
                end else if (&cmp_q) begin
                    state_d = (&idn_q) ? FINISHED : DRAIN;
                end
            end
            DRAIN: begin
                if (wdog_fire || (&idn_q)) state_d = FINISHED;
            end
            FINISHED: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (ctrl.clear_i) state_d = IDLE;
    end

    always_comb begin
        ctrl.in_start_o  = '0;
        ctrl.out_start_o = '0;
        ctrl.done_o      = 1'b0;
        case (state_q)
            START: begin
                ctrl.in_start_o  = '1;
                ctrl.out_start_o = '1;
            end
            FINISHED: begin
                ctrl.done_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q      <= 1'b0;
            engine_en_q <= 1'b0;
        end else begin
            busy_q      <= (state_d != IDLE);
            engine_en_q <= (state_d == COMPUTE) || (state_d == DRAIN);
        end
    end

    // Per-sink transfer counters with sticky complete flags; a sink that is
    // already complete freezes its counter and flags any further handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < N_OUT; k++) cnt_q[k] <= '0;
            cmp_q <= '0;
            idn_q <= '0;
            ovf_q <= 1'b0;
        end else if (ctrl.clear_i) begin
            for (int k = 0; k < N_OUT; k++) cnt_q[k] <= '0;
            cmp_q <= '0;
            idn_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (start_acc) ovf_q <= 1'b0;
            if (state_q == FINISHED) begin
                for (int k = 0; k < N_OUT; k++) cnt_q[k] <= '0;
                cmp_q <= '0;
                idn_q <= '0;
            end
            if (active) begin
                idn_q <= idn_q | ctrl.in_done_i;
                for (int k = 0; k < N_OUT; k++) begin
                    if (hs[k]) begin
                        if (cmp_q[k]) begin
                            ovf_q <= 1'b1;
                        end else if (cnt_q[k] == ctrl.cnt_limit_i[k*CNT_W +: CNT_W]) begin
                            cmp_q[k] <= 1'b1;
                        end else begin
                            cnt_q[k] <= cnt_q[k] + CNT_W'(1);
                        end
                    end
                end
            end
        end
    end

`ifdef MDC_CTRL_WATCHDOG_EN
    logic [WDOG_W-1:0] wdog_q;
    logic              activity;

    assign activity  = (|hs) || (|ctrl.in_done_i);
    assign wdog_fire = active && (&wdog_q);

    // Counts consecutive cycles without any sink handshake or source done.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else if (ctrl.clear_i) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (start_acc) begin
                timeout_q <= 1'b0;
            end else if (wdog_fire) begin
                timeout_q <= 1'b1;
            end
            if (!active || activity || wdog_fire) begin
                wdog_q <= '0;
            end else begin
                wdog_q <= wdog_q + WDOG_W'(1);
            end
        end
    end
`else
    assign wdog_fire = 1'b0;
    // Constant 0 for every legal WDOG_W; the width only matters with the watchdog.
    assign timeout_q = (WDOG_W == 0);
`endif

    assign ctrl.busy_o      = busy_q;
    assign ctrl.engine_en_o = engine_en_q;
    assign ctrl.ovf_o       = ovf_q;
    assign ctrl.timeout_o   = timeout_q;

endmodule
